// File: rtl/apx_float_to_int.sv
// -----------------------------------------------------------------------------
// apx_float_to_int
//
// Converts IEEE-754 single-precision values coming out of the approximate
// float adder into 32-bit two's-complement signed integers, truncating toward
// zero. The low NAB_M mantissa bits are zeroed when the operand is captured,
// so the converter never resolves more precision than the adder produced.
//
// Optional feature (compile-time macro APX_F2I_SATURATE_EN):
//   defined   : positive out-of-range and +inf give 32'h7FFFFFFF; negative
//               out-of-range, -inf and NaN give 32'h80000000.
//   undefined : every out-of-range/inf/NaN input gives 32'h80000000.
//   Latency is the same in both modes.
//
// Parameters:
//   NAB_M         number of low mantissa bits forced to zero (0..22)
//
// Ports:
//   clk           clock
//   rst           synchronous, active-high reset
//   input_a       IEEE-754 single operand
//   input_a_stb   upstream data valid
//   input_a_ack   block ready to accept input_a
//   output_z      signed integer result
//   output_z_stb  result valid
//   output_z_ack  downstream accepted result
//
// Handshake: on both sides a word moves on a rising clock edge where stb and
// ack are both high. The producer holds its data and stb until that edge; the
// block drives input_a_ack only in get_a and holds output_z/output_z_stb
// stable in put_z until output_z_ack is seen. Only one conversion is in flight.
// -----------------------------------------------------------------------------
module apx_float_to_int #(
  parameter int NAB_M = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  typedef enum logic [2:0] {
    GET_A         = 3'd0,
    UNPACK        = 3'd1,
    SPECIAL_CASES = 3'd2,
    CONVERT       = 3'd3,
    PUT_Z         = 3'd4
  } state_t;

  localparam logic [31:0] OOR_CODE = 32'h8000_0000;
`ifdef APX_F2I_SATURATE_EN
  localparam logic [31:0] POS_SAT  = 32'h7FFF_FFFF;
`endif

  // Mantissa bits kept on capture; the low NAB_M bits are cleared.
  localparam logic [22:0] KEEP_MASK = 23'h7F_FFFF << NAB_M;

  // FSM state, kept as a named enum so checkers can bind to it directly.
  state_t state;
  state_t next_state;

  logic [31:0]       a;
  logic [31:0]       m;
  logic signed [9:0] e;
  logic              s;

  logic              ack_d;
  logic              stb_d;
  logic              special_hit;
  logic [31:0]       special_z;

  logic              a_xfer;
  logic              z_xfer;

  assign a_xfer = input_a_ack && input_a_stb;
  assign z_xfer = output_z_stb && output_z_ack;

  // ---------------------------------------------------------------------------
  // State register. Handshake outputs are registered from next_state so that
  // they are low while rst is held and rise one cycle after it is released.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= GET_A;
      input_a_ack  <= 1'b0;
      output_z_stb <= 1'b0;
    end else begin
      state        <= next_state;
      input_a_ack  <= ack_d;
      output_z_stb <= stb_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    case (state)
      GET_A:         if (a_xfer) next_state = UNPACK;
      UNPACK:        next_state = SPECIAL_CASES;
      SPECIAL_CASES: next_state = special_hit ? PUT_Z : CONVERT;
      CONVERT:       if (e == 10'sd31) next_state = PUT_Z;
      PUT_Z:         if (z_xfer) next_state = GET_A;
      default:       next_state = GET_A;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: values the handshake registers take on the next edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    ack_d = (next_state == GET_A);
    stb_d = (next_state == PUT_Z);
  end

  // ---------------------------------------------------------------------------
  // Special-case classification, first matching rule wins. Evaluated while
  // in special_cases, where e and s already hold the unpacked operand.
  // ---------------------------------------------------------------------------
  always_comb begin
    special_hit = 1'b1;
    special_z   = 32'h0;
    if (a[30:23] == 8'h00) begin
      special_z = 32'h0;                       // zero or denormal
    end else if (a[30:23] == 8'hFF) begin
`ifdef APX_F2I_SATURATE_EN
      // Only +inf saturates high; -inf and every NaN use the invalid code.
      special_z = (!s && (a[22:0] == 23'h0)) ? POS_SAT : OOR_CODE;
`else
      special_z = OOR_CODE;
`endif
    end else if (e[9]) begin
      special_z = 32'h0;                       // |x| < 1
    end else if (e >= 10'sd31) begin
`ifdef APX_F2I_SATURATE_EN
      special_z = s ? OOR_CODE : POS_SAT;
`else
      special_z = OOR_CODE;
`endif
    end else begin
      special_hit = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath. m holds the mantissa with its implicit one at bit 31, so the
  // integer value is m >> (31 - e); convert performs that shift one bit per
  // cycle, which also truncates toward zero for both signs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      a        <= 32'h0;
      m        <= 32'h0;
      e        <= 10'sd0;
      s        <= 1'b0;
      output_z <= 32'h0;
    end else begin
      case (state)
        GET_A: begin
          if (a_xfer) a <= {input_a[31:23], input_a[22:0] & KEEP_MASK};
        end
        UNPACK: begin
          s <= a[31];
          e <= $signed({2'b00, a[30:23]}) - 10'sd127;
          m <= {1'b1, a[22:0], 8'h00};
        end
        SPECIAL_CASES: begin
          if (special_hit) output_z <= special_z;
        end
        CONVERT: begin
          if (e != 10'sd31) begin
            m <= m >> 1;
            e <= e + 10'sd1;
          end else begin
            output_z <= s ? -m : m;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apx_float_to_int.sv
// -----------------------------------------------------------------------------
// tb_apx_float_to_int
//
// Bench for apx_float_to_int. Two instances share the input stream: one with
// the default NAB_M = 20 and one with NAB_M = 0, so each conversion is checked
// against both precisions. Directed vectors come from a table, random operands
// are checked against an arithmetic model, and back-pressure / mid-operation
// reset are exercised as hand-written sequences.
// -----------------------------------------------------------------------------
module tb_apx_float_to_int;

`ifdef APX_F2I_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam logic [31:0] POS_OOR = SAT ? 32'h7FFF_FFFF : 32'h8000_0000;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack;

  logic        a0_ack;
  logic [31:0] z0;
  logic        z0_stb;

  always #5 clk = ~clk;

  apx_float_to_int #(.NAB_M(20)) dut (
    .clk          (clk),
    .rst          (rst),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack)
  );

  apx_float_to_int #(.NAB_M(0)) dut0 (
    .clk          (clk),
    .rst          (rst),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (a0_ack),
    .output_z     (z0),
    .output_z_stb (z0_stb),
    .output_z_ack (output_z_ack)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: value = 1.frac * 2^(exp-127), truncated toward zero.
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] ref_conv(input logic [31:0] a, input int nab);
    logic [22:0] frac;
    int          ex;
    longint      mag;
    frac = a[22:0] & (23'h7F_FFFF << nab);
    if (a[30:23] == 8'h00) return 32'h0;
    if (a[30:23] == 8'hFF) begin
      if (SAT && !a[31] && frac == 23'h0) return 32'h7FFF_FFFF;
      return 32'h8000_0000;
    end
    ex = int'(a[30:23]) - 127;
    if (ex < 0) return 32'h0;
    if (ex >= 31) return (SAT && !a[31]) ? 32'h7FFF_FFFF : 32'h8000_0000;
    mag = longint'({1'b1, frac});
    if (ex >= 23) mag = mag << (ex - 23);
    else          mag = mag >> (23 - ex);
    if (a[31]) mag = -mag;
    return mag[31:0];
  endfunction

  function automatic int ref_lat(input logic [31:0] a);
    int ex;
    if (a[30:23] == 8'h00 || a[30:23] == 8'hFF) return 3;
    ex = int'(a[30:23]) - 127;
    if (ex < 0 || ex >= 31) return 3;
    return 35 - ex;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: one full transaction. Called and returning #1 after a posedge.
  // lat counts posedges from the accepting edge (counted as 1) until stb high.
  // ---------------------------------------------------------------------------
  task automatic convert(input logic [31:0] a, output logic [31:0] z,
                         output logic [31:0] zz0, output int lat);
    int n;
    n = 0;
    while (!input_a_ack && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!input_a_ack) begin
      checks++; errors++;
      $display("FAIL ack_timeout a=%h", a);
    end
    input_a     = a;
    input_a_stb = 1'b1;
    @(posedge clk); #1;
    input_a_stb = 1'b0;
    lat = 1;
    while (!output_z_stb && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!output_z_stb) begin
      checks++; errors++;
      $display("FAIL stb_timeout a=%h", a);
    end
    check32("stb_nab0_agree", {31'h0, z0_stb}, {31'h0, output_z_stb});
    z   = output_z;
    zz0 = z0;
    output_z_ack = 1'b1;
    @(posedge clk); #1;
    output_z_ack = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] a;
    logic [31:0] z;
    logic [31:0] z0;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] z, zz0, exp_z;
    int          lat, n, stb_seen;

    vecs.push_back('{32'h4120_0000, 32'h0000_000A, 32'h0000_000A, 32});
    vecs.push_back('{32'hC070_0000, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 34});
    vecs.push_back('{32'h4070_0000, 32'h0000_0003, 32'h0000_0003, 34});
    vecs.push_back('{32'h3F00_0000, 32'h0000_0000, 32'h0000_0000, 3});
    vecs.push_back('{32'h3F80_0000, 32'h0000_0001, 32'h0000_0001, 35});
    vecs.push_back('{32'h4B00_0001, 32'h0080_0000, 32'h0080_0001, 12});
    vecs.push_back('{32'h4F00_0000, POS_OOR,       POS_OOR,       3});
    vecs.push_back('{32'h7F80_0000, POS_OOR,       POS_OOR,       3});
    vecs.push_back('{32'hCF00_0000, 32'h8000_0000, 32'h8000_0000, 3});
    vecs.push_back('{32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 3});
    vecs.push_back('{32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 3});
    vecs.push_back('{32'h7FC0_0000, 32'h8000_0000, 32'h8000_0000, 3});
    vecs.push_back('{32'h4EFF_FFFF, 32'h7800_0000, 32'h7FFF_FF80, 5});
    vecs.push_back('{32'hCEFF_FFFF, 32'h8800_0000, 32'h8000_0080, 5});

    // Reset
    rst          = 1'b1;
    input_a      = 32'h0;
    input_a_stb  = 1'b0;
    output_z_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check32("rst_input_a_ack", {31'h0, input_a_ack}, 32'h0);
    check32("rst_output_z_stb", {31'h0, output_z_stb}, 32'h0);
    check32("rst_output_z", output_z, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    check32("post_rst_ack", {31'h0, input_a_ack}, 32'h1);

    // Table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      exp_q.push_back(vecs[i].z);
      convert(vecs[i].a, z, zz0, lat);
      exp_z = exp_q.pop_front();
      check32($sformatf("vec%0d_z", i), z, exp_z);
      check32($sformatf("vec%0d_z_nab0", i), zz0, vecs[i].z0);
      check_int($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
    end

    // Randomized operands against the model
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[30:23] = 8'($urandom_range(120, 162));
      exp_q.push_back(ref_conv(a, 20));
      convert(a, z, zz0, lat);
      exp_z = exp_q.pop_front();
      check32($sformatf("rnd%0d_z a=%h", i, a), z, exp_z);
      check32($sformatf("rnd%0d_z_nab0 a=%h", i, a), zz0, ref_conv(a, 0));
      check_int($sformatf("rnd%0d_lat a=%h", i, a), lat, ref_lat(a));
    end

    // Back-pressure: result held, upstream stb ignored while in put_z
    input_a     = 32'h4120_0000;
    input_a_stb = 1'b1;
    @(posedge clk); #1;
    input_a_stb = 1'b0;
    n = 0;
    while (!output_z_stb && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check32("bp_first_z", output_z, 32'h0000_000A);
    input_a     = 32'h3F00_0000;
    input_a_stb = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check32($sformatf("bp%0d_z", i), output_z, 32'h0000_000A);
      check32($sformatf("bp%0d_stb", i), {31'h0, output_z_stb}, 32'h1);
      check32($sformatf("bp%0d_in_ack", i), {31'h0, input_a_ack}, 32'h0);
    end
    output_z_ack = 1'b1;
    @(posedge clk); #1;
    output_z_ack = 1'b0;
    check32("bp_handoff_stb", {31'h0, output_z_stb}, 32'h0);
    check32("bp_handoff_in_ack", {31'h0, input_a_ack}, 32'h1);
    // The still-asserted stb is accepted on the next edge.
    @(posedge clk); #1;
    input_a_stb = 1'b0;
    check32("bp_next_accepted", {31'h0, input_a_ack}, 32'h0);
    lat = 1;
    while (!output_z_stb && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check_int("bp_next_lat", lat, 3);
    check32("bp_next_z", output_z, 32'h0);
    output_z_ack = 1'b1;
    @(posedge clk); #1;
    output_z_ack = 1'b0;

    // Reset in the middle of convert
    input_a     = 32'h3F80_0000;
    input_a_stb = 1'b1;
    @(posedge clk); #1;
    input_a_stb = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check32("midrst_stb", {31'h0, output_z_stb}, 32'h0);
    check32("midrst_in_ack", {31'h0, input_a_ack}, 32'h0);
    check32("midrst_z", output_z, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    check32("midrst_release_ack", {31'h0, input_a_ack}, 32'h1);
    stb_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (output_z_stb) stb_seen++;
    end
    check_int("midrst_no_stale_result", stb_seen, 0);
    convert(32'hC120_0000, z, zz0, lat);
    check32("midrst_after_z", z, 32'hFFFF_FFF6);
    check_int("midrst_after_lat", lat, 32);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apx_float_to_int.md
Name: apx_float_to_int

Overview:
- Converts IEEE-754 single-precision values from the approximate float adder's output stream to 32-bit two's-complement signed integers, truncating toward zero.
- Sits directly downstream of the adder and consumes its output_z/stb/ack stream unchanged.
- Mantissa bits below NAB_M are discarded on capture, so the converter never resolves more precision than the adder produced.
- Multi-cycle FSM with the same stb/ack handshake on both sides.

Parameters:
- NAB_M, 20, number of low mantissa bits (input bits [NAB_M-1:0]) forced to zero on capture. Legal range 0..22.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- input_a  input  32  IEEE-754 single operand
- input_a_stb  input  1  upstream data valid
- input_a_ack  output  1  block ready to accept input_a
- output_z  output  32  signed integer result
- output_z_stb  output  1  result valid
- output_z_ack  input  1  downstream accepted result

Behaviour:
- Reset values: input_a_ack=0, output_z_stb=0, output_z=0, state=get_a.
- Reset mid-operation returns to get_a and discards any captured operand or pending result.
- States: get_a, unpack, special_cases, convert, put_z.
- get_a:
  - Drive input_a_ack=1.
  - Transfer occurs on a posedge with input_a_ack && input_a_stb.
  - On transfer: capture input_a, drop ack next cycle, go to unpack.
- unpack:
  - s = a[31].
  - e = a[30:23] - 127, 10-bit signed.
  - m = 32-bit {1'b1, a[22:NAB_M], NAB_M zeros, 8'b0}.
  - Go to special_cases.
- special_cases, first matching rule applies:
  - Exponent field 0 (zero or denormal) -> z=0.
  - Exponent field 255 (inf/NaN) -> z=32'h80000000.
  - e < 0 (|x| < 1) -> z=0.
  - e >= 31 -> z=32'h80000000.
  - Any rule hit goes to put_z; otherwise go to convert.
- convert:
  - While e < 31: m <= m >> 1, e <= e + 1, one shift per cycle.
  - When e == 31: z = s ? -m : m, go to put_z.
- put_z:
  - output_z_stb=1, output_z=z.
  - On stb && output_z_ack: stb drops next cycle, return to get_a.
  - output_z is held stable while stb is high and ack is low.
- Latency, counted in posedges from the accepting edge to the first cycle stb is high:
  - Special cases: 3.
  - Normal inputs (0 <= e <= 30): 35 - e.
- Throughput: one conversion in flight. input_a_ack stays low from the accepting edge until the result is handed off.
- Simultaneous events: input_a_stb asserted during put_z is ignored until the block returns to get_a. rst has priority over every handshake.
- Truncation toward zero: -3.75 -> -3, 3.75 -> 3.
- 32'h80000000 is the single out-of-range/invalid code. -2^31 exactly also yields 32'h80000000.

Optional Feature:
- Macro: APX_F2I_SATURATE_EN.
- Defined, saturating mode:
  - Positive out-of-range (e >= 31 with s=0) -> 32'h7FFFFFFF.
  - +inf -> 32'h7FFFFFFF.
  - -inf and negative out-of-range -> 32'h80000000.
  - NaN -> 32'h80000000.
- Undefined: every out-of-range/inf/NaN input returns 32'h80000000.
- Latency is identical in both modes.

Test Plan:
- 32'h41200000 (10.0), ack held high -> output_z=32'h0000000A, stb rises 32 edges after accept.
- 32'hC0700000 (-3.75) -> 32'hFFFFFFFD. 32'h3F000000 (0.5) -> 32'h00000000 after 3 edges.
- 32'h4B000001 (8388609.0), NAB_M=20 -> 32'h00800000 (approximation drops the LSB). With NAB_M=0 -> 32'h00800001.
- 32'h4F000000 (2^31) and 32'h7F800000 (+inf):
  - Without macro -> 32'h80000000.
  - With APX_F2I_SATURATE_EN -> 32'h7FFFFFFF.
  - 32'hCF000000 -> 32'h80000000 in both modes.
- 32'h00000001 (denormal) -> 0. 32'h80000000 (-0) -> 0. 32'h7FC00000 (NaN) -> 32'h80000000 in both modes.
- Back-pressure and reset:
  - Hold output_z_ack=0 for 10 cycles -> output_z stable, stb=1, input_a_ack=0.
  - Assert rst for one cycle mid-convert -> stb=0, ack=0 on the following edge, input_a_ack=1 one cycle after rst deasserts.
